// File: rtl/mrd_fsm_seq_ctrl_if.sv
// Handshake and status bundle between the frame sequencer and its environment.
// The slave side is the sequencer; the master side supplies samples and stage pulses.
interface mrd_fsm_seq_ctrl_if #(
    parameter int wPTS = 12
);
    logic            clr;
    logic            sink_valid;
    logic            sink_sop;
    logic            sink_eop;
    logic [wPTS-1:0] cfg_dftpts;
    logic [2:0]      cfg_num_factors;
    logic            rd_end;
    logic            wr_end;
    logic            source_end;
    logic [2:0]      fsm;
    logic [2:0]      fsm_r;
    logic [2:0]      cur_stage;
    logic [2:0]      num_factors_lat;
    logic [wPTS-1:0] dftpts_lat;
    logic            sink_ready;
    logic            busy;
    logic            frame_done;
    logic            err_len;

    modport master (
        output clr, sink_valid, sink_sop, sink_eop, cfg_dftpts, cfg_num_factors,
               rd_end, wr_end, source_end,
        input  fsm, fsm_r, cur_stage, num_factors_lat, dftpts_lat,
               sink_ready, busy, frame_done, err_len
    );

    modport slave (
        input  clr, sink_valid, sink_sop, sink_eop, cfg_dftpts, cfg_num_factors,
               rd_end, wr_end, source_end,
        output fsm, fsm_r, cur_stage, num_factors_lat, dftpts_lat,
               sink_ready, busy, frame_done, err_len
    );
endinterface

// File: rtl/mrd_fsm_seq_ctrl.sv
// Frame sequencer for the mixed-radix DFT memory engine. Accepts one frame,
// drains the write pipe, alternates Rd / Wait_wr_end once per radix stage,
// then hands the frame to the Source side. fsm and fsm_r are shared with the
// memory read/write blocks.
module mrd_fsm_seq_ctrl #(
    parameter int WAIT_CYC = 4,
    parameter int wPTS     = 12
) (
    input logic               clk,
    input logic               rst_n,
    mrd_fsm_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SINK        = 3'd1,
        WAIT_TO_RD  = 3'd2,
        RD          = 3'd3,
        WAIT_WR_END = 3'd4,
        SOURCE      = 3'd5
    } state_t;

    localparam logic [3:0]      WAIT_LAST = 4'(WAIT_CYC - 1);
    localparam logic [wPTS-1:0] ONE_PT    = wPTS'(1);

    state_t          state, state_nx;
    logic [2:0]      fsm_r;
    logic [2:0]      stage, stage_nx;
    logic [2:0]      nf_lat, nf_lat_nx;
    logic [wPTS-1:0] dp_lat, dp_lat_nx;
    logic [wPTS-1:0] sink_cnt, sink_cnt_nx, cnt_inc;
    logic [3:0]      wait_cnt, wait_cnt_nx;
    logic            done, done_nx;
    logic            err, err_nx;

    // Next-state, counters, latches and pulse decisions; abort overrides everything
    always_comb begin
        state_nx    = state;
        stage_nx    = stage;
        nf_lat_nx   = nf_lat;
        dp_lat_nx   = dp_lat;
        sink_cnt_nx = sink_cnt;
        wait_cnt_nx = '0;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        cnt_inc     = sink_cnt + ONE_PT;

        case (state)
            IDLE: begin
                if (bus.sink_valid && bus.sink_sop) begin
                    nf_lat_nx   = (bus.cfg_num_factors == 3'd0) ? 3'd1 : bus.cfg_num_factors;
                    dp_lat_nx   = bus.cfg_dftpts;
                    sink_cnt_nx = ONE_PT;
                    if (bus.sink_eop) begin
                        state_nx = WAIT_TO_RD;
                        err_nx   = (bus.cfg_dftpts != ONE_PT);
                    end else if (bus.cfg_dftpts == ONE_PT) begin
                        // single-point frame is already full on its SOP beat
                        state_nx = WAIT_TO_RD;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = SINK;
                    end
                end
            end
            SINK: begin
                // a repeated SOP is just another data beat
                if (bus.sink_valid) begin
                    sink_cnt_nx = cnt_inc;
                    if (bus.sink_eop) begin
                        state_nx = WAIT_TO_RD;
                        err_nx   = (cnt_inc != dp_lat);
                    end else if (cnt_inc == dp_lat) begin
                        state_nx = WAIT_TO_RD;
                        err_nx   = 1'b1;
                    end
                end
            end
            WAIT_TO_RD: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nx = RD;
                    stage_nx = 3'd0;
                end else begin
                    wait_cnt_nx = wait_cnt + 4'd1;
                end
            end
            RD: begin
                // a wr_end coinciding with rd_end is dropped on purpose
                if (bus.rd_end) begin
                    state_nx = WAIT_WR_END;
                end
            end
            WAIT_WR_END: begin
                if (bus.wr_end) begin
                    if (stage == nf_lat - 3'd1) begin
                        state_nx = SOURCE;
                    end else begin
                        state_nx = RD;
                        stage_nx = stage + 3'd1;
                    end
                end
            end
            SOURCE: begin
                if (bus.source_end) begin
                    state_nx = IDLE;
                    stage_nx = 3'd0;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                stage_nx = 3'd0;
            end
        endcase

        if (bus.clr) begin
            state_nx    = IDLE;
            stage_nx    = 3'd0;
            nf_lat_nx   = nf_lat;
            dp_lat_nx   = dp_lat;
            sink_cnt_nx = sink_cnt;
            wait_cnt_nx = '0;
            done_nx     = 1'b0;
            err_nx      = 1'b0;
        end
    end

    // State, delayed state copy, counters, latches and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fsm_r    <= 3'd0;
            stage    <= 3'd0;
            nf_lat   <= 3'd0;
            dp_lat   <= '0;
            sink_cnt <= '0;
            wait_cnt <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            fsm_r    <= state;
            stage    <= stage_nx;
            nf_lat   <= nf_lat_nx;
            dp_lat   <= dp_lat_nx;
            sink_cnt <= sink_cnt_nx;
            wait_cnt <= wait_cnt_nx;
            done     <= done_nx;
            err      <= err_nx;
        end
    end

    assign bus.fsm             = state;
    assign bus.fsm_r           = fsm_r;
    assign bus.cur_stage       = stage;
    assign bus.num_factors_lat = nf_lat;
    assign bus.dftpts_lat      = dp_lat;
    assign bus.sink_ready      = (state == IDLE) || (state == SINK);
    assign bus.busy            = (state != IDLE);
    assign bus.frame_done      = done;
    assign bus.err_len         = err;
endmodule
